// File: rtl/effect_scheduler_if.sv
// effect_scheduler_if: codec-side sample handshakes, effect handshake and processed-pair outputs
//   l_ready/l_data/l_ack, r_ready/r_data/r_ack : receive-side sample handshakes
//   fx_data_ready/fx_data                      : samples handed to the effect
//   fx_read_enable/fx_o_data/fx_data_valid     : effect acceptance and result
//   o_left/o_right/o_valid                     : processed pair to the transmit side
//   timeout_err                                : sticky watchdog abort flag
//   bypass                                     : only when EFFECT_BYPASS_EN is defined
//   modport master is the scheduler; modport slave is its environment
interface effect_scheduler_if #(
   parameter int d_width = 16
);
   logic               l_ready;
   logic [d_width-1:0] l_data;
   logic               l_ack;
   logic               r_ready;
   logic [d_width-1:0] r_data;
   logic               r_ack;
   logic               fx_data_ready;
   logic [d_width-1:0] fx_data;
   logic               fx_read_enable;
   logic [d_width-1:0] fx_o_data;
   logic               fx_data_valid;
   logic [d_width-1:0] o_left;
   logic [d_width-1:0] o_right;
   logic               o_valid;
   logic               timeout_err;
`ifdef EFFECT_BYPASS_EN
   logic               bypass;
`endif
   modport master (
`ifdef EFFECT_BYPASS_EN
      input  bypass,
`endif
      input  l_ready, l_data, r_ready, r_data, fx_read_enable, fx_o_data, fx_data_valid,
      output l_ack, r_ack, fx_data_ready, fx_data, o_left, o_right, o_valid, timeout_err
   );
   modport slave (
`ifdef EFFECT_BYPASS_EN
      output bypass,
`endif
      output l_ready, l_data, r_ready, r_data, fx_read_enable, fx_o_data, fx_data_valid,
      input  l_ack, r_ack, fx_data_ready, fx_data, o_left, o_right, o_valid, timeout_err
   );
endinterface

// File: rtl/effect_scheduler.sv
// effect_scheduler: runs L then R samples through one shared effect and emits the pair atomically
//   clk, reset : clock and asynchronous active-high reset
//   bus        : effect_scheduler_if.master (sample handshakes, effect handshake, pair outputs)
//   Optional macro EFFECT_BYPASS_EN adds bus.bypass: a pair latched with bypass=1 skips the effect.
module effect_scheduler #(
   parameter int d_width = 16,
   parameter int TIMEOUT = 255
) (
   input logic                clk,
   input logic                reset,
   effect_scheduler_if.master bus
);
   localparam int CW = $clog2(TIMEOUT) + 1;
   typedef enum logic [2:0] {IDLE, SEND_L, WAIT_L, GET_R, SEND_R, WAIT_R} state_t;
   state_t             state_q, state_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic [d_width-1:0] dry_q, dry_d;
   logic [d_width-1:0] wet_l_q, wet_l_d;
   logic [d_width-1:0] o_left_q, o_left_d;
   logic [d_width-1:0] o_right_q, o_right_d;
   logic               l_ack_q, l_ack_d;
   logic               r_ack_q, r_ack_d;
   logic               o_valid_q, o_valid_d;
   logic               fx_rdy_q, fx_rdy_d;
   logic               terr_q, terr_d;
   logic               byp_q, byp_d;
   logic               byp_in, in_send, in_wait, cap, expire;
   logic [d_width-1:0] wet;
`ifdef EFFECT_BYPASS_EN
   assign byp_in = bus.bypass;
`else
   assign byp_in = 1'b0;
`endif
   assign in_send = (state_q == SEND_L) || (state_q == SEND_R);
   assign in_wait = (state_q == WAIT_L) || (state_q == WAIT_R);
   assign cap     = (in_send && bus.fx_read_enable && bus.fx_data_valid) || (in_wait && bus.fx_data_valid);
   // watchdog abort: the last allowed cycle passed without a result
   assign expire  = (in_send || in_wait) && (cnt_q == CW'(TIMEOUT - 1)) && !cap;
   // an aborted channel falls back to its dry sample
   assign wet     = cap ? bus.fx_o_data : dry_q;
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      dry_d     = dry_q;
      wet_l_d   = wet_l_q;
      o_left_d  = o_left_q;
      o_right_d = o_right_q;
      l_ack_d   = 1'b0;
      r_ack_d   = 1'b0;
      o_valid_d = 1'b0;
      fx_rdy_d  = fx_rdy_q;
      terr_d    = terr_q;
      byp_d     = byp_q;
      case (state_q)
         IDLE: if (bus.l_ready) begin
            dry_d    = bus.l_data;
            wet_l_d  = bus.l_data;
            l_ack_d  = 1'b1;
            cnt_d    = '0;
            byp_d    = byp_in;
            fx_rdy_d = !byp_in;
            state_d  = byp_in ? GET_R : SEND_L;
         end
         SEND_L, WAIT_L: begin
            cnt_d = cnt_q + 1'b1;
            if (cap || expire) begin
               wet_l_d  = wet;
               fx_rdy_d = 1'b0;
               terr_d   = terr_q || expire;
               state_d  = GET_R;
            end else if (state_q == SEND_L && bus.fx_read_enable) begin
               fx_rdy_d = 1'b0;
               state_d  = WAIT_L;
            end
         end
         GET_R: if (bus.r_ready) begin
            dry_d     = bus.r_data;
            r_ack_d   = 1'b1;
            cnt_d     = '0;
            fx_rdy_d  = !byp_q;
            o_left_d  = byp_q ? wet_l_q : o_left_q;
            o_right_d = byp_q ? bus.r_data : o_right_q;
            o_valid_d = byp_q;
            state_d   = byp_q ? IDLE : SEND_R;
         end
         SEND_R, WAIT_R: begin
            cnt_d = cnt_q + 1'b1;
            if (cap || expire) begin
               o_left_d  = wet_l_q;
               o_right_d = wet;
               o_valid_d = 1'b1;
               fx_rdy_d  = 1'b0;
               terr_d    = terr_q || expire;
               state_d   = IDLE;
            end else if (state_q == SEND_R && bus.fx_read_enable) begin
               fx_rdy_d = 1'b0;
               state_d  = WAIT_R;
            end
         end
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         dry_q     <= '0;
         wet_l_q   <= '0;
         o_left_q  <= '0;
         o_right_q <= '0;
         l_ack_q   <= 1'b0;
         r_ack_q   <= 1'b0;
         o_valid_q <= 1'b0;
         fx_rdy_q  <= 1'b0;
         terr_q    <= 1'b0;
         byp_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         dry_q     <= dry_d;
         wet_l_q   <= wet_l_d;
         o_left_q  <= o_left_d;
         o_right_q <= o_right_d;
         l_ack_q   <= l_ack_d;
         r_ack_q   <= r_ack_d;
         o_valid_q <= o_valid_d;
         fx_rdy_q  <= fx_rdy_d;
         terr_q    <= terr_d;
         byp_q     <= byp_d;
      end
   end
   assign bus.l_ack         = l_ack_q;
   assign bus.r_ack         = r_ack_q;
   assign bus.fx_data_ready = fx_rdy_q;
   assign bus.fx_data       = dry_q;
   assign bus.o_left        = o_left_q;
   assign bus.o_right       = o_right_q;
   assign bus.o_valid       = o_valid_q;
   assign bus.timeout_err   = terr_q;
endmodule
